// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and operand-extension helper for the shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mult_state_t;

    // Extension bit for a WIDTH+1 adder operand: replicate the MSB only when signed.
    function automatic logic ext(input logic val, input logic signed_mode);
        return val & signed_mode;
    endfunction

endpackage

// File: rtl/add_sub_unit.sv
// add_sub_unit: WIDTH+1-bit adder/subtractor producing the next {X,A} from A and M.
module add_sub_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    input  logic             sub,
    input  logic             signed_mode,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] ea;
    logic [WIDTH:0] em;

    assign ea  = {ext(a[WIDTH-1], signed_mode), a};
    assign em  = {ext(m[WIDTH-1], signed_mode), m};
    // Subtraction is A + ~M + 1; the carry beyond X falls off the WIDTH+1 result.
    assign sum = ea + (sub ? ~em : em) + (WIDTH + 1)'(sub);

endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequential shift-add multiplier with control FSM, step counter and A/B/X/M datapath.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    mult_state_t      state;
    mult_state_t      state_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] m;
    logic             x;
    logic             mode;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    logic             last;

    assign last = cnt == CW'(WIDTH - 1);
    assign Aval = a;
    assign Bval = b;
    assign Xval = x;

    // The final step of a signed multiply subtracts: the multiplier MSB carries weight -2^(WIDTH-1).
    add_sub_unit #(.WIDTH(WIDTH)) u_add_sub (
        .a           (a),
        .m           (m),
        .sub         (mode & last),
        .signed_mode (mode),
        .sum         (sum)
    );

    always_comb begin
        state_n = (state == IDLE)  ? ((Run && !ClearA_LoadB) ? ADD : IDLE) :
                  (state == ADD)   ? SHIFT :
                  (state == SHIFT) ? (last ? DONE : ADD) :
                                     (Run ? DONE : IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            m     <= '0;
            x     <= 1'b0;
            mode  <= 1'b0;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_n;
            Busy  <= (state == ADD) || (state == SHIFT);
            Done  <= state == DONE;
            case (state)
                IDLE: begin
                    if (ClearA_LoadB) begin
                        a <= '0;
                        x <= 1'b0;
                        b <= S;
                    end else if (Run) begin
                        a    <= '0;
                        x    <= 1'b0;
                        m    <= S;
                        mode <= Signed_Mode;
                        cnt  <= '0;
                    end
                end
                ADD: begin
                    if (b[0]) {x, a} <= sum;
                end
                SHIFT: begin
                    {x, a, b} <= {mode & x, x, a, b[WIDTH-1:1]};
                    cnt       <= last ? cnt : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: scoreboard bench for seq_mult_ctrl at WIDTH=8 and WIDTH=16.
module tb_seq_mult_ctrl;

    typedef struct packed {
        logic       ld;
        logic [7:0] bv;
        logic [7:0] sv;
        logic       md;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, ld, sm;
    logic [7:0]  s, a, b;
    logic        x, busy, done;
    logic        run16, ld16, sm16;
    logic [15:0] s16, a16, b16;
    logic        x16, busy16, done16;

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];
    logic [32:0] exp16_q[$];
    logic [7:0]  bcur;
    logic [15:0] bcur16;

    op_t ops [0:6] = '{
        '{1'b1, 8'hC5, 8'h07, 1'b1},
        '{1'b1, 8'hFF, 8'hFF, 1'b0},
        '{1'b1, 8'hFF, 8'hFF, 1'b1},
        '{1'b1, 8'h80, 8'h80, 1'b1},
        '{1'b0, 8'h00, 8'h02, 1'b1},
        '{1'b1, 8'h63, 8'h02, 1'b1},
        '{1'b0, 8'h00, 8'h02, 1'b1}
    };

    seq_mult_ctrl #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .Run(run), .ClearA_LoadB(ld), .Signed_Mode(sm), .S(s),
        .Aval(a), .Bval(b), .Xval(x), .Busy(busy), .Done(done)
    );

    seq_mult_ctrl #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(rst), .Run(run16), .ClearA_LoadB(ld16), .Signed_Mode(sm16), .S(s16),
        .Aval(a16), .Bval(b16), .Xval(x16), .Busy(busy16), .Done(done16)
    );

    function automatic logic [16:0] model8(input logic [7:0] bb, input logic [7:0] ss, input logic md);
        logic [15:0] p;
        p = md ? {{8{bb[7]}}, bb} * {{8{ss[7]}}, ss} : {8'h00, bb} * {8'h00, ss};
        return {md & p[15], p};
    endfunction

    function automatic logic [32:0] model16(input logic [15:0] bb, input logic [15:0] ss, input logic md);
        logic [31:0] p;
        p = md ? {{16{bb[15]}}, bb} * {{16{ss[15]}}, ss} : {16'h0, bb} * {16'h0, ss};
        return {md & p[31], p};
    endfunction

    // All drivers start and end on a falling edge.
    task automatic load8(input logic [7:0] v);
        ld = 1'b1; s = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic go8(input logic [7:0] v, input logic md, output int lat);
        s = v; sm = md; run = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic rel8;
        run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load16(input logic [15:0] v);
        ld16 = 1'b1; s16 = v;
        @(negedge clk);
        ld16 = 1'b0;
    endtask

    task automatic go16(input logic [15:0] v, input logic md, output int lat);
        s16 = v; sm16 = md; run16 = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done16 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        run16 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if ({a, b, x, busy, done} !== 19'd0) begin
            errors++;
            $display("FAIL reset8: got %h want 0", {a, b, x, busy, done});
        end
        checks++;
        if ({a16, b16, x16, busy16, done16} !== 35'd0) begin
            errors++;
            $display("FAIL reset16: got %h want 0", {a16, b16, x16, busy16, done16});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a, b, x, busy, done} !== 19'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want 0", {a, b, x, busy, done});
        end
    endtask

    task automatic test_products;
        int lat;
        logic [16:0] e;
        for (int i = 0; i < 7; i++) begin
            if (ops[i].ld) begin
                load8(ops[i].bv);
                bcur = ops[i].bv;
            end
            exp_q.push_back(model8(bcur, ops[i].sv, ops[i].md));
            go8(ops[i].sv, ops[i].md, lat);
            checks++;
            if (lat !== 17) begin
                errors++;
                $display("FAIL products[%0d] latency: got %0d want 17", i, lat);
            end
            e = exp_q.pop_front();
            checks++;
            if ({x, a, b} !== e) begin
                errors++;
                $display("FAIL products[%0d] result: got %h want %h", i, {x, a, b}, e);
            end
            bcur = e[7:0];
            rel8();
        end
    endtask

    task automatic test_control;
        int lat;
        logic [16:0] e;
        load8(8'h5A);
        s = 8'h33; sm = 1'b0; run = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        #1;
        checks++;
        if ({a, b, x, busy, done} !== 19'd0) begin
            errors++;
            $display("FAIL reset_midop: got %h want 0", {a, b, x, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({a, b, x, busy, done} !== 19'd0) begin
            errors++;
            $display("FAIL reset_midop_idle: got %h want 0", {a, b, x, busy, done});
        end
        ld = 1'b1; run = 1'b1; s = 8'h0B; sm = 1'b0;
        @(negedge clk);
        ld = 1'b0;
        checks++;
        if ({b, busy} !== {8'h0B, 1'b0}) begin
            errors++;
            $display("FAIL load_over_run: got b=%h busy=%b want b=0b busy=0", b, busy);
        end
        bcur = 8'h0B;
        exp_q.push_back(model8(bcur, 8'h0D, 1'b0));
        go8(8'h0D, 1'b0, lat);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL load_over_run latency: got %0d want 17", lat);
        end
        e = exp_q.pop_front();
        checks++;
        if ({x, a, b} !== e) begin
            errors++;
            $display("FAIL load_over_run result: got %h want %h", {x, a, b}, e);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({done, x, a, b} !== {1'b1, e}) begin
            errors++;
            $display("FAIL done_hold: got %h want %h", {done, x, a, b}, {1'b1, e});
        end
        bcur = e[7:0];
        rel8();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL done_release: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_ignored;
        int lat;
        logic [16:0] e;
        load8(8'h21);
        bcur = 8'h21;
        exp_q.push_back(model8(bcur, 8'h13, 1'b0));
        s = 8'h13; sm = 1'b0; run = 1'b1;
        repeat (4) @(negedge clk);
        ld = 1'b1; s = 8'hAA; sm = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_midop: got %b want 1", busy);
        end
        @(negedge clk);
        ld = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        checks++;
        if ({done, x, a, b} !== {1'b1, e}) begin
            errors++;
            $display("FAIL ignored_inputs: got %h want %h", {done, x, a, b}, {1'b1, e});
        end
        bcur = e[7:0];
        rel8();
    endtask

    task automatic test_random;
        int lat;
        logic [16:0] e;
        logic [7:0] sv;
        logic md;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                bcur = 8'($urandom);
                load8(bcur);
            end
            sv = 8'($urandom);
            md = 1'($urandom_range(0, 1));
            exp_q.push_back(model8(bcur, sv, md));
            go8(sv, md, lat);
            e = exp_q.pop_front();
            checks++;
            if ({lat, x, a, b} !== {17, e}) begin
                errors++;
                $display("FAIL random[%0d]: got lat=%0d %h want lat=17 %h (b=%h s=%h md=%b)",
                         i, lat, {x, a, b}, e, bcur, sv, md);
            end
            bcur = e[7:0];
            rel8();
        end
    endtask

    task automatic test_wide;
        int lat;
        logic [32:0] e;
        logic [15:0] sv;
        logic md;
        load16(16'hFFFF);
        bcur16 = 16'hFFFF;
        exp16_q.push_back(model16(bcur16, 16'hFFFF, 1'b0));
        go16(16'hFFFF, 1'b0, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL wide latency: got %0d want 33", lat);
        end
        e = exp16_q.pop_front();
        checks++;
        if ({x16, a16, b16} !== e) begin
            errors++;
            $display("FAIL wide result: got %h want %h", {x16, a16, b16}, e);
        end
        bcur16 = e[15:0];
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                bcur16 = 16'($urandom);
                load16(bcur16);
            end
            sv = 16'($urandom);
            md = 1'($urandom_range(0, 1));
            exp16_q.push_back(model16(bcur16, sv, md));
            go16(sv, md, lat);
            e = exp16_q.pop_front();
            checks++;
            if ({lat, x16, a16, b16} !== {33, e}) begin
                errors++;
                $display("FAIL wide_random[%0d]: got lat=%0d %h want lat=33 %h", i, lat, {x16, a16, b16}, e);
            end
            bcur16 = e[15:0];
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; ld = 1'b0; sm = 1'b0; s = '0;
        run16 = 1'b0; ld16 = 1'b0; sm16 = 1'b0; s16 = '0;
        bcur = '0; bcur16 = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_products();
        test_control();
        test_ignored();
        test_random();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
